// File: rtl/gate_out_filter.sv
// rtl/gate_out_filter.sv - synchronize, debounce and edge-count the gates_area out_or level
module gate_out_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             out_or_i,
  input  logic             clear,
  output logic             filt_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_sat
);

  localparam int DBC_W = $clog2(STABLE_CYCLES);
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_t;

  state_t           state, state_nxt;
  logic [DBC_W-1:0] dbc, dbc_nxt;
  logic             s1, s2;
  logic             filt_nxt, rise_nxt, fall_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      state      <= STABLE_LO;
      dbc        <= '0;
      filt_out   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      edge_cnt   <= '0;
      cnt_sat    <= 1'b0;
    end else begin
      s1         <= out_or_i;
      s2         <= s1;
      state      <= state_nxt;
      dbc        <= dbc_nxt;
      filt_out   <= filt_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      edge_cnt   <= cnt_nxt;
      cnt_sat    <= sat_nxt;
    end
  end

  // dbc counts consecutive samples at the pending level; any opposite sample abandons the pend
  always_comb begin
    state_nxt = state;
    dbc_nxt   = dbc;
    filt_nxt  = filt_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (s2) begin
          state_nxt = PEND_HI;
          dbc_nxt   = DBC_W'(1);
        end
      end
      PEND_HI: begin
        if (!s2) begin
          state_nxt = STABLE_LO;
          dbc_nxt   = '0;
        end else if (dbc == DBC_LAST) begin
          state_nxt = STABLE_HI;
          dbc_nxt   = '0;
          filt_nxt  = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          dbc_nxt = dbc + DBC_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          state_nxt = PEND_LO;
          dbc_nxt   = DBC_W'(1);
        end
      end
      PEND_LO: begin
        if (s2) begin
          state_nxt = STABLE_HI;
          dbc_nxt   = '0;
        end else if (dbc == DBC_LAST) begin
          state_nxt = STABLE_LO;
          dbc_nxt   = '0;
          filt_nxt  = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          dbc_nxt = dbc + DBC_W'(1);
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        dbc_nxt   = '0;
      end
    endcase
  end

  // clear takes priority over a rise accepted on the same edge
  always_comb begin
    cnt_nxt = edge_cnt;
    if (clear) begin
      cnt_nxt = '0;
    end else if (rise_nxt && (edge_cnt != CNT_MAX)) begin
      cnt_nxt = edge_cnt + CNT_W'(1);
    end
    sat_nxt = (cnt_nxt == CNT_MAX);
  end

endmodule
